// File: rtl/maxpool_window_gen.sv
// 2x2 stride-2 window generator for the max-pool datapath: buffers one row and
// emits {a,b,c,d} per window. Optional win_count output under MAXPOOL_WIN_CNT_EN.
module maxpool_window_gen #(
  parameter int MAX_WIDTH  = 64,
  parameter int MAX_HEIGHT = 512
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [$clog2(MAX_WIDTH):0]    cfg_width,
  input  logic [$clog2(MAX_HEIGHT):0]   cfg_height,
  input  logic                          pix_valid,
  input  logic signed [7:0]             pix_data,
  output logic                          pix_ready,
  output logic                          win_valid,
  output logic signed [7:0]             win_a,
  output logic signed [7:0]             win_b,
  output logic signed [7:0]             win_c,
  output logic signed [7:0]             win_d,
  output logic                          busy,
  output logic                          frame_done,
  output logic                          cfg_err
`ifdef MAXPOOL_WIN_CNT_EN
  ,
  output logic [15:0]                   win_count
`endif
);

  localparam int WW = $clog2(MAX_WIDTH) + 1;
  localparam int HW = $clog2(MAX_HEIGHT) + 1;
  localparam int AW = $clog2(MAX_WIDTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ROW_TOP = 2'd1,
    ROW_BOT = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [WW-1:0]     width_q, width_d;
  logic [HW-1:0]     height_q, height_d;
  logic [WW-1:0]     col_q, col_d;
  logic [HW-1:0]     row_q, row_d;
  logic signed [7:0] hold_q, hold_d;
  logic              win_valid_q, win_valid_d;
  logic signed [7:0] win_a_q, win_a_d;
  logic signed [7:0] win_b_q, win_b_d;
  logic signed [7:0] win_c_q, win_c_d;
  logic signed [7:0] win_d_q, win_d_d;
  logic              frame_done_q, frame_done_d;
  logic              cfg_err_q, cfg_err_d;

  logic signed [7:0] linebuf_q [MAX_WIDTH];
  logic              lb_we;
  logic              accept;
  logic              col_last;
  logic              cfg_ok;
  logic [AW-1:0]     col_idx;
  logic [AW-1:0]     col_even_idx;
  logic [HW-1:0]     row_next;

  assign pix_ready    = (state_q == ROW_TOP) || (state_q == ROW_BOT);
  assign busy         = (state_q != IDLE);
  assign accept       = pix_valid && pix_ready;
  assign col_last     = (col_q == (width_q - WW'(1)));
  assign col_idx      = col_q[AW-1:0];
  assign col_even_idx = {col_idx[AW-1:1], 1'b0};
  assign row_next     = row_q + HW'(2);

  assign cfg_ok = !cfg_width[0]  && (cfg_width  >= WW'(2)) && (cfg_width  <= WW'(MAX_WIDTH)) &&
                  !cfg_height[0] && (cfg_height >= HW'(2)) && (cfg_height <= HW'(MAX_HEIGHT));

  always_comb begin
    state_d      = state_q;
    width_d      = width_q;
    height_d     = height_q;
    col_d        = col_q;
    row_d        = row_q;
    hold_d       = hold_q;
    cfg_err_d    = cfg_err_q;
    win_valid_d  = 1'b0;
    win_a_d      = win_a_q;
    win_b_d      = win_b_q;
    win_c_d      = win_c_q;
    win_d_d      = win_d_q;
    frame_done_d = (state_q == DONE);
    lb_we        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            width_d   = cfg_width;
            height_d  = cfg_height;
            col_d     = '0;
            row_d     = '0;
            cfg_err_d = 1'b0;
            state_d   = ROW_TOP;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end

      ROW_TOP: begin
        if (accept) begin
          lb_we = 1'b1;
          if (col_last) begin
            col_d   = '0;
            state_d = ROW_BOT;
          end else begin
            col_d = col_q + WW'(1);
          end
        end
      end

      ROW_BOT: begin
        if (accept) begin
          // Even column parks the bottom-left pixel; odd column completes the window.
          if (!col_q[0]) begin
            hold_d = pix_data;
          end else begin
            win_valid_d = 1'b1;
            win_a_d     = linebuf_q[col_even_idx];
            win_b_d     = linebuf_q[col_idx];
            win_c_d     = hold_q;
            win_d_d     = pix_data;
          end
          if (col_last) begin
            col_d   = '0;
            row_d   = row_next;
            state_d = (row_next == height_q) ? DONE : ROW_TOP;
          end else begin
            col_d = col_q + WW'(1);
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      width_q      <= '0;
      height_q     <= '0;
      col_q        <= '0;
      row_q        <= '0;
      hold_q       <= '0;
      win_valid_q  <= 1'b0;
      win_a_q      <= '0;
      win_b_q      <= '0;
      win_c_q      <= '0;
      win_d_q      <= '0;
      frame_done_q <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      width_q      <= width_d;
      height_q     <= height_d;
      col_q        <= col_d;
      row_q        <= row_d;
      hold_q       <= hold_d;
      win_valid_q  <= win_valid_d;
      win_a_q      <= win_a_d;
      win_b_q      <= win_b_d;
      win_c_q      <= win_c_d;
      win_d_q      <= win_d_d;
      frame_done_q <= frame_done_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  // Line buffer holds only the current top row; no reset needed.
  always_ff @(posedge clk) begin
    if (lb_we) begin
      linebuf_q[col_idx] <= pix_data;
    end
  end

  assign win_valid  = win_valid_q;
  assign win_a      = win_a_q;
  assign win_b      = win_b_q;
  assign win_c      = win_c_q;
  assign win_d      = win_d_q;
  assign frame_done = frame_done_q;
  assign cfg_err    = cfg_err_q;

`ifdef MAXPOOL_WIN_CNT_EN
  logic [15:0] win_count_q, win_count_d;

  always_comb begin
    win_count_d = win_count_q;
    if ((state_q == IDLE) && start && cfg_ok) begin
      win_count_d = '0;
    end else if (win_valid_q && (win_count_q != 16'hFFFF)) begin
      win_count_d = win_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_count_q <= '0;
    end else begin
      win_count_q <= win_count_d;
    end
  end

  assign win_count = win_count_q;
`endif

endmodule
